// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch redirect/flush/halt controller (optional trap path: FETCH_CTRL_TRAP_EN)
module fetch_ctrl #(
  parameter int ADDR         = 32,
  parameter int FLUSH_CYCLES = 2   // 1..15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            br_valid_i,
  input  logic [ADDR-1:0] br_addr_i,
  input  logic            trap_valid_i,
  input  logic [ADDR-1:0] trap_addr_i,
  input  logic            halt_i,
  input  logic            resume_i,
  input  logic            dec_stall_i,
  output logic            pc_branch_o,
  output logic [ADDR-1:0] pc_addr_o,
  output logic            pc_stall_o,
  output logic            flush_o,
  output logic [1:0]      state_o,
  output logic [15:0]     redirect_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            pc_branch_q, pc_branch_d;
  logic [ADDR-1:0] pc_addr_q, pc_addr_d;
  logic            pc_stall_q, pc_stall_d;
  logic            flush_q, flush_d;
  logic [15:0]     redirect_cnt_q, redirect_cnt_d;

  logic            trap_req;
  logic [ADDR-1:0] trap_addr;
  logic            br_req;
  logic            redirect_acc;
  logic [ADDR-1:0] redirect_addr;

`ifdef FETCH_CTRL_TRAP_EN
  assign trap_req  = trap_valid_i;
  assign trap_addr = trap_addr_i;
`else
  // Trap inputs stay on the port list but have no effect in this build.
  logic unused_trap;
  assign unused_trap = ^{trap_valid_i, trap_addr_i};
  assign trap_req    = 1'b0;
  assign trap_addr   = '0;
`endif

  // Branches are not honoured while halted; a trap always is.
  assign br_req        = br_valid_i && (state_q != ST_HALT);
  assign redirect_acc  = trap_req || br_req;
  assign redirect_addr = trap_req ? trap_addr : br_addr_i;

  // Next-state and next-output computation; redirects take precedence over everything.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_branch_d    = 1'b0;
    pc_addr_d      = pc_addr_q;
    pc_stall_d     = pc_stall_q;
    flush_d        = 1'b0;
    redirect_cnt_d = redirect_cnt_q;

    if (redirect_acc) begin
      state_d     = ST_FLUSH;
      cnt_d       = FLUSH_LOAD;
      pc_branch_d = 1'b1;
      pc_addr_d   = redirect_addr;
      pc_stall_d  = 1'b0;
      flush_d     = 1'b1;
      if (redirect_cnt_q != 16'hFFFF) begin
        redirect_cnt_d = redirect_cnt_q + 16'd1;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (halt_i) begin
            state_d    = ST_HALT;
            pc_stall_d = 1'b1;
          end else begin
            pc_stall_d = dec_stall_i;
          end
        end
        ST_FLUSH: begin
          // Decode stall is ignored for the whole bubble, including the exit cycle.
          if (cnt_q <= 4'd1) begin
            cnt_d      = 4'd0;
            state_d    = halt_i ? ST_HALT : ST_RUN;
            pc_stall_d = halt_i;
          end else begin
            cnt_d      = cnt_q - 4'd1;
            flush_d    = 1'b1;
            pc_stall_d = 1'b0;
          end
        end
        ST_HALT: begin
          if (resume_i) begin
            state_d    = ST_RUN;
            pc_stall_d = dec_stall_i;
          end else begin
            pc_stall_d = 1'b1;
          end
        end
        default: begin
          state_d    = ST_RUN;
          cnt_d      = 4'd0;
          pc_stall_d = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; reset aborts any bubble or halt in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_RUN;
      cnt_q          <= 4'd0;
      pc_branch_q    <= 1'b0;
      pc_addr_q      <= '0;
      pc_stall_q     <= 1'b0;
      flush_q        <= 1'b0;
      redirect_cnt_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pc_branch_q    <= pc_branch_d;
      pc_addr_q      <= pc_addr_d;
      pc_stall_q     <= pc_stall_d;
      flush_q        <= flush_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign pc_branch_o    = pc_branch_q;
  assign pc_addr_o      = pc_addr_q;
  assign pc_stall_o     = pc_stall_q;
  assign flush_o        = flush_q;
  assign state_o        = state_q;
  assign redirect_cnt_o = redirect_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl with randomized stimulus
module tb_fetch_ctrl;
  localparam int ADDR = 32;
  localparam int FC   = 2;
`ifdef FETCH_CTRL_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            br_valid_i;
  logic [ADDR-1:0] br_addr_i;
  logic            trap_valid_i;
  logic [ADDR-1:0] trap_addr_i;
  logic            halt_i;
  logic            resume_i;
  logic            dec_stall_i;
  logic            pc_branch_o;
  logic [ADDR-1:0] pc_addr_o;
  logic            pc_stall_o;
  logic            flush_o;
  logic [1:0]      state_o;
  logic [15:0]     redirect_cnt_o;

  always #5 clk = ~clk;

  fetch_ctrl #(.ADDR(ADDR), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset),
    .br_valid_i(br_valid_i), .br_addr_i(br_addr_i),
    .trap_valid_i(trap_valid_i), .trap_addr_i(trap_addr_i),
    .halt_i(halt_i), .resume_i(resume_i), .dec_stall_i(dec_stall_i),
    .pc_branch_o(pc_branch_o), .pc_addr_o(pc_addr_o), .pc_stall_o(pc_stall_o),
    .flush_o(flush_o), .state_o(state_o), .redirect_cnt_o(redirect_cnt_o)
  );

  typedef struct {
    int              mode;
    bit              br;
    logic [ADDR-1:0] addr;
    bit              stall;
    bit              flush;
    int              cnt;
  } exp_t;

  exp_t            exp_q[$];
  logic [ADDR-1:0] addr_q[$];
  int              checks   = 0;
  int              failures = 0;

  // Reference model: mode 0=running, 1=bubble, 2=halted; left = bubble cycles remaining.
  int              m_mode = 0, m_left = 0, m_cnt = 0;
  bit              m_br = 0, m_stall = 0, m_flush = 0;
  logic [ADDR-1:0] m_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit rst_n, input bit br, input logic [ADDR-1:0] ba,
                       input bit tr, input logic [ADDR-1:0] ta,
                       input bit h, input bit r, input bit d);
    bit trap, redirect;
    exp_t e;
    if (!rst_n) begin
      m_mode = 0; m_left = 0; m_cnt = 0; m_br = 0; m_stall = 0; m_flush = 0; m_addr = '0;
    end else begin
      trap     = TRAP_ON && tr;
      redirect = trap || (br && m_mode != 2);
      m_br     = redirect;
      if (redirect) begin
        m_addr  = trap ? ta : ba;
        m_mode  = 1;
        m_left  = FC;
        m_flush = 1;
        m_stall = 0;
        m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        addr_q.push_back(m_addr);
      end else if (m_mode == 0) begin
        m_flush = 0;
        if (h) begin m_mode = 2; m_stall = 1; end
        else m_stall = d;
      end else if (m_mode == 1) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_mode = h ? 2 : 0; m_stall = h; m_flush = 0;
        end else begin
          m_flush = 1; m_stall = 0;
        end
      end else begin
        m_flush = 0;
        if (r) begin m_mode = 0; m_stall = d; end
        else m_stall = 1;
      end
    end
    e.mode = m_mode; e.br = m_br; e.addr = m_addr;
    e.stall = m_stall; e.flush = m_flush; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus; returns #1 after the edge so directed checks can follow.
  task automatic step(input bit rst_n, input bit br, input logic [ADDR-1:0] ba,
                      input bit tr, input logic [ADDR-1:0] ta,
                      input bit h, input bit r, input bit d);
    @(negedge clk);
    reset = rst_n; br_valid_i = br; br_addr_i = ba; trap_valid_i = tr; trap_addr_i = ta;
    halt_i = h; resume_i = r; dec_stall_i = d;
    model(rst_n, br, ba, tr, ta, h, r, d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, '0, 0, '0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, '0, 0, '0, 0, 0, 0);
    step(0, 0, '0, 0, '0, 0, 0, 0);
  endtask

  // Monitor: every clock, compare DUT outputs against the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state_o", 64'(state_o), 64'(e.mode));
        chk("pc_branch_o", 64'(pc_branch_o), 64'(e.br));
        chk("pc_addr_o", 64'(pc_addr_o), 64'(e.addr));
        chk("pc_stall_o", 64'(pc_stall_o), 64'(e.stall));
        chk("flush_o", 64'(flush_o), 64'(e.flush));
        chk("redirect_cnt_o", 64'(redirect_cnt_o), 64'(e.cnt));
        if (pc_branch_o === 1'b1) begin
          if (addr_q.size() == 0) chk("unexpected_redirect", 64'd1, 64'd0);
          else chk("redirect_target", 64'(pc_addr_o), 64'(addr_q.pop_front()));
        end
      end
    end
  end

  initial begin
    reset = 0; br_valid_i = 0; br_addr_i = '0; trap_valid_i = 0; trap_addr_i = '0;
    halt_i = 0; resume_i = 0; dec_stall_i = 0;

    // Reset state and quiet run
    do_reset();
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_addr", 64'(pc_addr_o), 64'd0);
    idle(5);
    chk("idle_flush", 64'(flush_o), 64'd0);
    chk("idle_cnt", 64'(redirect_cnt_o), 64'd0);

    // Single branch: one strobe, FC bubble cycles, back to run
    step(1, 1, 32'h100, 0, '0, 0, 0, 0);
    chk("br_strobe", 64'(pc_branch_o), 64'd1);
    chk("br_addr", 64'(pc_addr_o), 64'h100);
    idle(1);
    chk("br_flush2", 64'(flush_o), 64'd1);
    chk("br_strobe_once", 64'(pc_branch_o), 64'd0);
    idle(1);
    chk("br_back_run", 64'(state_o), 64'd0);
    chk("br_cnt", 64'(redirect_cnt_o), 64'd1);

    // Trap vs branch in the same cycle, with a decode stall present
    do_reset();
    step(1, 1, 32'h100, 1, 32'h8, 0, 0, 1);
    chk("prio_addr", 64'(pc_addr_o), TRAP_ON ? 64'h8 : 64'h100);
    chk("prio_stall", 64'(pc_stall_o), 64'd0);
    idle(3);

    // Halt, ignored branch, resume
    step(1, 0, '0, 0, '0, 1, 0, 0);
    chk("halt_state", 64'(state_o), 64'd2);
    chk("halt_stall", 64'(pc_stall_o), 64'd1);
    step(1, 1, 32'h444, 0, '0, 0, 0, 0);
    chk("halt_no_branch", 64'(pc_branch_o), 64'd0);
    step(1, 0, '0, 0, '0, 0, 1, 0);
    chk("resume_state", 64'(state_o), 64'd0);

    // Redirect during bubble restarts it; reset aborts a bubble
    step(1, 1, 32'h300, 0, '0, 0, 0, 0);
    idle(1);
    step(1, 1, 32'h200, 0, '0, 0, 0, 1);
    chk("reflush_addr", 64'(pc_addr_o), 64'h200);
    idle(1);
    chk("reflush_ext", 64'(flush_o), 64'd1);
    idle(1);
    chk("reflush_done", 64'(flush_o), 64'd0);
    step(1, 1, 32'h500, 0, '0, 0, 0, 0);
    step(0, 1, 32'h600, 1, 32'h700, 0, 0, 0);
    chk("rst_flush_state", 64'(state_o), 64'd0);
    chk("rst_flush_flush", 64'(flush_o), 64'd0);
    chk("rst_no_strobe", 64'(pc_branch_o), 64'd0);

    // Counter saturation: back-to-back branches
    do_reset();
    for (int i = 0; i < 65534; i++) step(1, 1, 32'(i), 0, '0, 0, 0, 0);
    chk("cnt_fffe", 64'(redirect_cnt_o), 64'hFFFE);
    for (int i = 0; i < 3; i++) step(1, 1, 32'hA0 + 32'(i), 0, '0, 0, 0, 0);
    chk("cnt_sat", 64'(redirect_cnt_o), 64'hFFFF);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99) >= 2,
           $urandom_range(99) < 15, 32'($urandom),
           $urandom_range(99) < 8,  32'($urandom),
           $urandom_range(99) < 10, $urandom_range(99) < 20,
           $urandom_range(99) < 30);
    end

    idle(2);
    @(posedge clk);
    #2;
    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("addr_queue_drained", 64'(addr_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL take parameter ADDR, default 32: PC/address width, matching the params include.
REQ-002 SHALL take parameter FLUSH_CYCLES, default 2, range 1..15: bubble cycles after a redirect.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port br_valid_i  input  1  branch-taken redirect request from execute.
REQ-006 SHALL have port br_addr_i  input  ADDR  branch target.
REQ-007 SHALL have port trap_valid_i  input  1  trap redirect request; ignored when the macro is off.
REQ-008 SHALL have port trap_addr_i  input  ADDR  trap vector.
REQ-009 SHALL have port halt_i  input  1  halt-fetch request.
REQ-010 SHALL have port resume_i  input  1  leave HALT.
REQ-011 SHALL have port dec_stall_i  input  1  downstream decode stall.
REQ-012 SHALL have port pc_branch_o  output  1  load strobe to the PC register.
REQ-013 SHALL have port pc_addr_o  output  ADDR  address loaded when pc_branch_o=1.
REQ-014 SHALL have port pc_stall_o  output  1  hold the PC.
REQ-015 SHALL have port flush_o  output  1  invalidate in-flight fetched instructions.
REQ-016 SHALL have port state_o  output  2  RUN=0, FLUSH=1, HALT=2.
REQ-017 SHALL have port redirect_cnt_o  output  16  count of accepted redirects.

Function
REQ-018 SHALL implement a 3-state FSM: RUN, FLUSH, HALT. All outputs are registered.
REQ-019 Request priority SHALL be trap > branch > halt > dec_stall.
REQ-020 In RUN or FLUSH, an accepted redirect at edge N SHALL give pc_branch_o=1 for exactly one cycle after N, with pc_addr_o equal to the winning address. The FSM SHALL enter FLUSH with its counter loaded to FLUSH_CYCLES.
REQ-021 In FLUSH: flush_o=1 and pc_stall_o=0.
  - The counter decrements each cycle.
  - When the counter reaches 0 the FSM returns to RUN, or to HALT if halt_i=1.
  - A new redirect restarts the counter; the latest target wins.
REQ-022 In RUN with no redirect and halt_i=1, the FSM SHALL enter HALT the next cycle. In HALT, pc_stall_o=1 continuously.
REQ-023 In HALT: resume_i=1 SHALL return the FSM to RUN the next cycle.
  - br_valid_i is ignored.
  - trap_valid_i (macro on) is accepted as in REQ-020; it leaves HALT and clears the halt.
REQ-024 In RUN: pc_stall_o SHALL equal dec_stall_i delayed one cycle; flush_o=0.
REQ-025 When a redirect and dec_stall_i occur in the same cycle, the redirect SHALL win. dec_stall_i SHALL be ignored in FLUSH.
REQ-026 redirect_cnt_o SHALL increment by 1 per accepted redirect and saturate at 0xFFFF (no wrap).
REQ-027 pc_addr_o SHALL hold its last value while pc_branch_o=0.

Reset
REQ-028 While reset=0 at a clock edge:
  - state=RUN, FLUSH counter=0;
  - pc_branch_o=0, pc_addr_o=0, pc_stall_o=0, flush_o=0, redirect_cnt_o=0.
REQ-029 Reset asserted mid-FLUSH or mid-HALT SHALL abort that state. No redirect strobe SHALL be issued for requests sampled during reset.

Configuration
REQ-030 Macro FETCH_CTRL_TRAP_EN defined: the trap path is active per REQ-019, REQ-020 and REQ-023.
REQ-031 Macro FETCH_CTRL_TRAP_EN undefined:
  - trap_valid_i and trap_addr_i remain ports but are ignored;
  - branch is the highest-priority request;
  - HALT exits only via resume_i.

Verification
REQ-032 Reset released, no requests for 5 cycles -> state_o=0, all outputs 0, redirect_cnt_o=0.
REQ-033 RUN, br_valid_i=1, br_addr_i=0x100 for 1 cycle, FLUSH_CYCLES=2 -> next cycle pc_branch_o=1, pc_addr_o=0x100; flush_o=1 for 2 cycles; then state_o=0; redirect_cnt_o=1.
REQ-034 Macro on, trap_valid_i=1 (0x8) and br_valid_i=1 (0x100) in the same cycle -> pc_addr_o=0x8, redirect_cnt_o=1. With the macro off the same stimulus gives pc_addr_o=0x100.
REQ-035 halt_i=1 in RUN -> state_o=2, pc_stall_o=1. br_valid_i pulse -> no pc_branch_o. resume_i=1 -> state_o=0 the next cycle.
REQ-036 FLUSH entered; 1 cycle later br_valid_i=1 (0x200) -> pc_branch_o=1, pc_addr_o=0x200, flush_o extended to 2 further cycles. reset=0 during FLUSH -> state_o=0, flush_o=0 the next cycle.
REQ-037 Preload redirect_cnt_o=0xFFFE via 0xFFFE redirects (or force), then 3 redirects -> redirect_cnt_o=0xFFFF.
